// File: rtl/serial_tx_pkg.sv
// Shared definitions for the parametrised serial transmitter.
//   txState_e  : transmitter FSM state encoding
//   calcParity : reduction-XOR parity of a zero-extended word, optionally inverted
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } txState_e;

  // Widest word the parity helper accepts. Zero-extension does not change
  // the XOR, so narrower words are simply cast up at the call site.
  localparam int PARITY_MAX_WIDTH = 256;

  function automatic logic calcParity(input logic [PARITY_MAX_WIDTH-1:0] word,
                                      input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/param_serial_tx_if.sv
// Handshake/status bundle between a word producer and param_serial_tx.
//   DataIn/Sample/StartTx : producer -> transmitter
//   FifoFull/FifoEmpty/Overflow/TxBusy/TxDone/DataOut : transmitter -> producer
interface param_serial_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  Sample;
  logic                  StartTx;
  logic                  FifoFull;
  logic                  FifoEmpty;
  logic                  Overflow;
  logic                  TxBusy;
  logic                  TxDone;
  logic                  DataOut;

  modport master (
    output DataIn, Sample, StartTx,
    input  FifoFull, FifoEmpty, Overflow, TxBusy, TxDone, DataOut
  );

  modport slave (
    input  DataIn, Sample, StartTx,
    output FifoFull, FifoEmpty, Overflow, TxBusy, TxDone, DataOut
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous word FIFO for the serial transmitter.
//   Clk, Reset (async, active-low)
//   wrData/wrEn : enqueue; dropped when full unless a read frees a slot
//   rdEn        : dequeue head (ignored when empty); rdData shows the head
//   full/empty  : registered from the next count
//   overflow    : one-cycle pulse after a dropped write
module serial_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] wrData,
  input  logic             wrEn,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             fullReg;
  logic             emptyReg;
  logic             overflowReg;
  logic             rdAccept;
  logic             wrAccept;

  assign rdAccept  = rdEn && !emptyReg;
  // A read at the same edge frees a slot, so a write into a full FIFO is kept.
  assign wrAccept  = wrEn && (!fullReg || rdAccept);
  assign countNext = count + CNT_W'(wrAccept) - CNT_W'(rdAccept);

  always_ff @(posedge Clk) begin
    if (wrAccept) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      fullReg     <= 1'b0;
      emptyReg    <= 1'b1;
      overflowReg <= 1'b0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + 1'b1;
      if (rdAccept) rdPtr <= rdPtr + 1'b1;
      count       <= countNext;
      fullReg     <= (countNext == CNT_W'(DEPTH));
      emptyReg    <= (countNext == '0);
      overflowReg <= wrEn && !wrAccept;
    end
  end

  assign rdData   = mem[rdPtr];
  assign full     = fullReg;
  assign empty    = emptyReg;
  assign overflow = overflowReg;
endmodule

// File: rtl/param_serial_tx.sv
// Parametrised serial transmitter: buffers words in a FIFO and shifts the
// head word out on DataOut, one bit per CLK_DIV clocks, with optional parity.
//   Clk, Reset (async, active-low)
//   bus (slave) : DataIn/Sample enqueue, StartTx launches a frame;
//                 FifoFull/FifoEmpty/Overflow buffer status;
//                 TxBusy during the frame, TxDone one-cycle end pulse, DataOut serial
module param_serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 2,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  param_serial_tx_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  txState_e              state;
  logic [DIV_W-1:0]      divCnt;
  logic [BIT_W-1:0]      bitCnt;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  parityReg;
  logic                  dataOutReg;
  logic                  txBusyReg;
  logic                  txDoneReg;

  logic [DATA_WIDTH-1:0] headWord;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic                  fifoOverflow;
  logic                  pop;
  logic                  divWrap;
  logic                  lastBit;
  logic                  firstBit;
  logic                  nextBit;
  logic [DATA_WIDTH-1:0] shifted;

  // StartTx is only honoured in IDLE with a word waiting; a same-edge Sample
  // into an empty FIFO is not visible yet, so there is no fall-through.
  assign pop = (state == IDLE) && bus.StartTx && !fifoEmpty;

  serial_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .wrData   (bus.DataIn),
    .wrEn     (bus.Sample),
    .rdEn     (pop),
    .rdData   (headWord),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .overflow (fifoOverflow)
  );

  assign divWrap  = (divCnt == DIV_W'(CLK_DIV - 1));
  assign lastBit  = (bitCnt == BIT_W'(DATA_WIDTH - 1));
  assign firstBit = (MSB_FIRST != 0) ? headWord[DATA_WIDTH-1] : headWord[0];
  assign nextBit  = (MSB_FIRST != 0) ? shiftReg[DATA_WIDTH-2] : shiftReg[1];
  assign shifted  = (MSB_FIRST != 0) ? (shiftReg << 1) : (shiftReg >> 1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      divCnt     <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityReg  <= 1'b0;
      dataOutReg <= 1'b0;
      txBusyReg  <= 1'b0;
      txDoneReg  <= 1'b0;
    end else begin
      txDoneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            // Word and its parity are captured here so later DataIn
            // activity cannot disturb the frame in flight.
            shiftReg   <= headWord;
            parityReg  <= calcParity(PARITY_MAX_WIDTH'(headWord), PARITY_ODD != 0);
            dataOutReg <= firstBit;
            txBusyReg  <= 1'b1;
            divCnt     <= '0;
            bitCnt     <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (divWrap) begin
            divCnt <= '0;
            if (lastBit) begin
              if (PARITY_EN != 0) begin
                dataOutReg <= parityReg;
                state      <= PARITY;
              end else begin
                dataOutReg <= 1'b0;
                txBusyReg  <= 1'b0;
                txDoneReg  <= 1'b1;
                state      <= DONE;
              end
            end else begin
              bitCnt     <= bitCnt + 1'b1;
              shiftReg   <= shifted;
              dataOutReg <= nextBit;
            end
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        PARITY: begin
          if (divWrap) begin
            divCnt     <= '0;
            dataOutReg <= 1'b0;
            txBusyReg  <= 1'b0;
            txDoneReg  <= 1'b1;
            state      <= DONE;
          end else begin
            divCnt <= divCnt + 1'b1;
          end
        end
        DONE: begin
          // TxDone was raised on entry and drops via the default above.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.FifoFull  = fifoFull;
  assign bus.FifoEmpty = fifoEmpty;
  assign bus.Overflow  = fifoOverflow;
  assign bus.TxBusy    = txBusyReg;
  assign bus.TxDone    = txDoneReg;
  assign bus.DataOut   = dataOutReg;
endmodule
